// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-channel valid/ready stream multiplexer with a registered
//               output stage. The source channel is either forced by index or
//               picked round-robin. Multi-beat packets lock the grant to their
//               channel until the last beat, so packets are never interleaved.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    input  logic               force_en,
    input  logic [SEL_W-1:0]   force_sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    // After reset last_grant points at the highest channel so the round-robin
    // search starts at channel 0.
    localparam logic [SEL_W-1:0] C_LAST_CH = SEL_W'(N - 1);

    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic             out_last_q,   out_last_d;
    logic [SEL_W-1:0] out_sel_q,    out_sel_d;
    logic             out_valid_q,  out_valid_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;
    logic             locked_q,     locked_d;
    logic [SEL_W-1:0] lock_ch_q,    lock_ch_d;

    logic             load;
    logic             xfer;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;
    logic             grant_last;

    // The output register can take a new beat when empty or being drained.
    assign load = !out_valid_q || out_ready;
    assign xfer = load && grant_valid;

    // Grant selection: an open packet lock wins, then the forced index, then
    // round-robin starting just after the previously granted channel.
    always_comb begin
        int   start;
        int   idx;
        logic found;
        grant       = '0;
        grant_valid = 1'b0;
        found       = 1'b0;
        start       = 0;
        idx         = 0;
        if (locked_q) begin
            grant       = lock_ch_q;
            grant_valid = in_valid[lock_ch_q];
        end else if (force_en) begin
            // Out-of-range forced indices simply produce no grant.
            if (int'(force_sel) < N) begin
                grant       = force_sel;
                grant_valid = in_valid[force_sel];
            end
        end else begin
            start = (int'(last_grant_q) + 1) % N;
            for (int k = 0; k < N; k++) begin
                idx = (start + k) % N;
                if (!found && in_valid[idx]) begin
                    found = 1'b1;
                    grant = SEL_W'(idx);
                end
            end
            grant_valid = found;
        end
    end

    // Route the granted channel's data and last flag, and raise its ready.
    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        in_ready   = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
                grant_last = in_last[i];
            end
            in_ready[i] = xfer && (grant == SEL_W'(i));
        end
    end

    // Next-state: capture a transferred beat, update lock and fairness
    // pointer, or drop out_valid when the register drains with nothing new.
    always_comb begin
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_sel_d    = out_sel_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        locked_d     = locked_q;
        lock_ch_d    = lock_ch_q;
        if (load) begin
            if (xfer) begin
                out_data_d   = grant_data;
                out_last_d   = grant_last;
                out_sel_d    = grant;
                out_valid_d  = 1'b1;
                last_grant_d = grant;
                if (grant_last) begin
                    locked_d = 1'b0;
                end else begin
                    locked_d  = 1'b1;
                    lock_ch_d = grant;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State and output registers; reset abandons any open packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= C_LAST_CH;
            locked_q     <= 1'b0;
            lock_ch_q    <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_sel_q    <= out_sel_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
            locked_q     <= locked_d;
            lock_ch_q    <= lock_ch_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, WIDTH-bit stream multiplexer with a registered output and valid/ready handshakes on every port. It is the sequential successor to the team's fixed 2:1 4-bit selector and feeds shared downstream datapaths from several producers. Channel choice is either forced through a select input, matching the old behaviour, or made by a round-robin arbiter. Multi-beat packets marked with `last` are never interleaved.

## Interface
Parameters:
- `WIDTH`, default 4: data width per channel.
- `N`, default 4: number of input channels, N >= 2.
- `SEL_W`, default $clog2(N): width of the select fields (derived; do not override).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous and active-low.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_last`  in  N  per-channel end-of-packet flag, qualified by in_valid.
- `in_ready`  out  N  per-channel ready; at most one bit is high.
- `force_en`  in  1  1 = fixed selection by force_sel; 0 = round-robin.
- `force_sel`  in  SEL_W  forced channel index.
- `out_data`  out  WIDTH  registered data.
- `out_last`  out  1  registered last flag.
- `out_sel`  out  SEL_W  registered index of the source channel for the current beat.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream ready.

## Operation
- Output stage is one register. `load = !out_valid || out_ready`.
- Grant selection, computed combinationally each cycle, in strict priority order:
  1. `locked = 1`: grant = lock_ch, valid only if in_valid[lock_ch].
  2. `force_en = 1`: grant = force_sel, valid only if force_sel < N and in_valid[force_sel]. If force_sel >= N, no grant.
  3. Otherwise round-robin: pick the first i with in_valid[i] set, searching from (last_grant+1) mod N upward and wrapping.
- `in_ready[i] = load && grant_valid && grant == i`.
- Transfer on channel g: in_valid[g] && in_ready[g]. On the same edge:
  - out_data <= in_data[g], out_last <= in_last[g], out_sel <= g, out_valid <= 1.
  - last_grant <= g.
  - If in_last[g] = 0: locked <= 1 and lock_ch <= g. If in_last[g] = 1: locked <= 0.
- `load` high with no transfer: out_valid <= 0. The data, last and sel registers hold.
- `load` low: all output registers and state hold, and every in_ready is 0.
- Lock rules:
  - The lock overrides force_en and force_sel. A forced switch takes effect only after the current packet's last beat.
  - A single-beat packet (in_last = 1 on the first beat) never locks.
  - While locked, other channels are starved even if the locked channel idles. This is intentional.
- Internal state: last_grant (SEL_W bits), locked (1 bit), lock_ch (SEL_W bits).

## Timing
- Reset (asynchronous assert, any cycle, including mid-packet):
  - Outputs: out_valid = 0, out_data = 0, out_last = 0, out_sel = 0.
  - State: locked = 0, lock_ch = 0, last_grant = N-1, so channel 0 has first priority after reset.
  - A packet cut by reset is abandoned with no recovery beat.
- Release is synchronised externally; the first transfer can occur on the first rising edge after rst_n rises.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat per cycle while out_ready stays high.
- Combinational paths:
  - in_ready depends combinationally on out_ready, in_valid, force_en and force_sel. Producers must not make in_valid depend on in_ready.
  - There is no combinational path from any input to out_*.
- Backpressure: while out_valid = 1 and out_ready = 0, the out_* outputs are stable and unchanged.
- Simultaneous pop and push (out_valid = 1, out_ready = 1, transfer): the register is replaced with the new beat and out_valid stays 1 without a bubble.
- Round-robin wrap-around: with last_grant = N-1, the search starts at channel 0.

## Test plan
- Reset then forced mode, N=4, WIDTH=4: force_en=1, force_sel=2, all valid, in_data=0x_A_B_C_D (channel 3 down to 0), in_last=all 1, out_ready=1 -> out_data=0xB, out_sel=2 one cycle later, repeating every cycle; in_ready=0b0100.
- Round-robin fairness: all four channels valid with single-beat packets, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles.
- Packet lock: channel 1 sends a 3-beat packet (last only on beat 3) while channel 2 is valid, and force_sel is switched to 2 mid-packet -> three consecutive beats with out_sel=1, then out_sel=2; in_ready[2] stays 0 until channel 1's last beat transfers.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_* stable, in_ready=0; on release, the held beat is accepted and the next beat loads on the same edge with no bubble.
- Invalid force: force_en=1, force_sel=5 with N=4 (SEL_W=2 cannot encode 5, so use N=5 and force_sel=7 with SEL_W=3) -> in_ready all 0, out_valid falls to 0 after the current beat drains.
- Reset mid-packet: assert rst_n=0 asynchronously between beats 2 and 3 of a locked packet -> all outputs go to zero immediately; after release, channel 0 wins the first round-robin grant with locked = 0.
